// File: rtl/instr_encoder_loader.sv
// Packs decoded MIPS fields into 32-bit instruction words and streams them
// into instruction memory through a word write port, behind a 2-entry FIFO.
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic        e_clk,
    input  logic        e_rst,
    input  logic        e_i_start,
    input  logic        e_i_valid,
    output logic        e_o_ready,
    input  logic        e_i_last,
    input  logic [5:0]  e_i_opcode,
    input  logic [5:0]  e_i_funct,
    input  logic [4:0]  e_i_addr_rs,
    input  logic [4:0]  e_i_addr_rt,
    input  logic [4:0]  e_i_addr_rd,
    input  logic [15:0] e_i_imm,
    output logic        e_o_we,
    input  logic        e_i_wready,
    output logic [31:0] e_o_waddr,
    output logic [31:0] e_o_wdata,
    output logic [1:0]  e_o_state,
    output logic        e_o_done,
    output logic [15:0] e_o_count,
    output logic        e_o_err_op,
    output logic        e_o_err_full,
    output logic [7:0]  e_o_drop_cnt
);

    localparam int unsigned IW    = 32;
    localparam int unsigned ACW   = $clog2(IMEM_WORDS + 1);
    localparam int unsigned DEPTH = 2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LOAD  = 6'h23;
    localparam logic [5:0] OP_STORE = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [IW-1:0]  mem_q [DEPTH];
    logic [IW-1:0]  mem_d [DEPTH];
    logic           wr_ptr_q, wr_ptr_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic [1:0]     fifo_cnt_q, fifo_cnt_d;
    logic [ACW-1:0] acc_q, acc_d;
    logic [15:0]    count_q, count_d;
    logic [31:0]    waddr_q, waddr_d;
    logic           err_op_q, err_op_d;
    logic           err_full_q, err_full_d;
    logic [7:0]     drop_q, drop_d;
    logic           ready_q, ready_d;
    logic           we_q, we_d;
    logic [IW-1:0]  wdata_q, wdata_d;
    logic           done_q, done_d;

    logic           op_ok_c;
    logic [IW-1:0]  enc_c;
    logic           init_c, accept_c, push_c, pop_c, full_hit_c, drop_inc_c;

    // Opcode legality and field packing; shamt is always zero
    always_comb begin
        op_ok_c = 1'b0;
        enc_c   = {e_i_opcode, e_i_addr_rs, e_i_addr_rt, e_i_imm};
        case (e_i_opcode)
            OP_RTYPE: begin
                op_ok_c = 1'b1;
                enc_c   = {e_i_opcode, e_i_addr_rs, e_i_addr_rt, e_i_addr_rd, 5'b0, e_i_funct};
            end
            OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_LOAD, OP_STORE: op_ok_c = 1'b1;
            default: op_ok_c = 1'b0;
        endcase
    end

    // Handshake qualifiers; ready_q already encodes "in LOAD, not full, room left"
    assign init_c     = e_i_start && (state_q == S_IDLE || state_q == S_DONE);
    assign accept_c   = (state_q == S_LOAD) && e_i_valid && ready_q;
    assign push_c     = accept_c && op_ok_c;
    assign pop_c      = we_q && e_i_wready;
    assign full_hit_c = (state_q == S_LOAD) && e_i_valid && (acc_q == ACW'(IMEM_WORDS));
    assign drop_inc_c = (accept_c && !op_ok_c) || full_hit_c;

    // State register
    always_ff @(posedge e_clk) begin
        if (e_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (e_i_start) state_d = S_LOAD;
            S_LOAD:  if ((accept_c && e_i_last) || full_hit_c) state_d = S_DRAIN;
            S_DRAIN: if (fifo_cnt_d == 2'd0) state_d = S_DONE;
            S_DONE:  if (e_i_start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values, computed so every output is a flop
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        acc_d      = acc_q;
        count_d    = count_q;
        waddr_d    = waddr_q;
        err_op_d   = err_op_q;
        err_full_d = err_full_q;
        drop_d     = drop_q;

        if (init_c) begin
            waddr_d    = BASE_ADDR;
            count_d    = 16'd0;
            acc_d      = '0;
            err_op_d   = 1'b0;
            err_full_d = 1'b0;
            drop_d     = 8'd0;
        end
        if (push_c) begin
            mem_d[wr_ptr_q] = enc_c;
            wr_ptr_d        = ~wr_ptr_q;
            acc_d           = acc_q + ACW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
            waddr_d  = waddr_q + 32'd4;
            count_d  = count_q + 16'd1;
        end
        if (push_c && !pop_c)      fifo_cnt_d = fifo_cnt_q + 2'd1;
        else if (pop_c && !push_c) fifo_cnt_d = fifo_cnt_q - 2'd1;

        if (accept_c && !op_ok_c) err_op_d   = 1'b1;
        if (full_hit_c)           err_full_d = 1'b1;
        if (drop_inc_c && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

        ready_d = (state_d == S_LOAD) && (fifo_cnt_d != 2'd2) && (acc_d < ACW'(IMEM_WORDS));
        we_d    = (fifo_cnt_d != 2'd0);
        wdata_d = mem_d[rd_ptr_d];
        done_d  = (state_d == S_DONE);
    end

    // Datapath registers; reset empties the FIFO and clears every output
    always_ff @(posedge e_clk) begin
        if (e_rst) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
            acc_q      <= '0;
            count_q    <= 16'd0;
            waddr_q    <= BASE_ADDR;
            err_op_q   <= 1'b0;
            err_full_q <= 1'b0;
            drop_q     <= 8'd0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            waddr_q    <= waddr_d;
            err_op_q   <= err_op_d;
            err_full_q <= err_full_d;
            drop_q     <= drop_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
        end
    end

    assign e_o_ready    = ready_q;
    assign e_o_we       = we_q;
    assign e_o_waddr    = waddr_q;
    assign e_o_wdata    = wdata_q;
    assign e_o_state    = state_q;
    assign e_o_done     = done_q;
    assign e_o_count    = count_q;
    assign e_o_err_op   = err_op_q;
    assign e_o_err_full = err_full_q;
    assign e_o_drop_cnt = drop_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: encoding table, back-pressure, bad opcode, capacity limit, reset mid-load.
module tb_instr_encoder_loader;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;

    logic        e_clk = 1'b0;
    logic        e_rst = 1'b1;
    logic        start = 1'b0, valid = 1'b0, last = 1'b0, wready = 1'b0;
    logic [5:0]  opcode = '0, funct = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic [15:0] imm = '0;

    logic        ready0, we0, done0, eop0, efull0;
    logic [31:0] waddr0, wdata0;
    logic [1:0]  state0;
    logic [15:0] count0;
    logic [7:0]  drop0;
    logic        ready1, we1, done1, eop1, efull1;
    logic [31:0] waddr1, wdata1;
    logic [1:0]  state1;
    logic [15:0] count1;
    logic [7:0]  drop1;

    int checks = 0;
    int errors = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    vec_t vecs[12];

    always #5 e_clk = ~e_clk;

    instr_encoder_loader dut0 (
        .e_clk(e_clk), .e_rst(e_rst), .e_i_start(start), .e_i_valid(valid), .e_o_ready(ready0),
        .e_i_last(last), .e_i_opcode(opcode), .e_i_funct(funct), .e_i_addr_rs(rs),
        .e_i_addr_rt(rt), .e_i_addr_rd(rd), .e_i_imm(imm), .e_o_we(we0), .e_i_wready(wready),
        .e_o_waddr(waddr0), .e_o_wdata(wdata0), .e_o_state(state0), .e_o_done(done0),
        .e_o_count(count0), .e_o_err_op(eop0), .e_o_err_full(efull0), .e_o_drop_cnt(drop0)
    );

    instr_encoder_loader #(.IMEM_WORDS(4)) dut1 (
        .e_clk(e_clk), .e_rst(e_rst), .e_i_start(start), .e_i_valid(valid), .e_o_ready(ready1),
        .e_i_last(last), .e_i_opcode(opcode), .e_i_funct(funct), .e_i_addr_rs(rs),
        .e_i_addr_rt(rt), .e_i_addr_rd(rd), .e_i_imm(imm), .e_o_we(we1), .e_i_wready(wready),
        .e_o_waddr(waddr1), .e_o_wdata(wdata1), .e_o_state(state1), .e_o_done(done1),
        .e_o_count(count1), .e_o_err_op(eop1), .e_o_err_full(efull1), .e_o_drop_cnt(drop1)
    );

    // Record every completed memory write as {addr, data}
    always @(negedge e_clk) begin
        if (we0 && wready) q0.push_back({waddr0, wdata0});
        if (we1 && wready) q1.push_back({waddr1, wdata1});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        e_rst = 1'b1;
        repeat (n) @(posedge e_clk);
        #1 e_rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge e_clk);
        #1 start = 1'b0;
    endtask

    // Offer one tuple until the selected DUT's ready is seen, or budget expires
    task automatic send(input vec_t v, input logic is_last, input bit sel, input int budget,
                        output bit got);
        valid  = 1'b1;
        last   = is_last;
        opcode = v.op; funct = v.funct; rs = v.rs; rt = v.rt; rd = v.rd; imm = v.imm;
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge e_clk);
            if (sel ? ready1 : ready0) got = 1'b1;
            @(posedge e_clk);
            #1;
        end
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input string name);
        bit d = 1'b0;
        for (int n = 0; n < 200 && !d; n++) begin
            @(negedge e_clk);
            d = sel ? done1 : done0;
            @(posedge e_clk);
            #1;
        end
        chk(name, 32'(d), 32'd1);
    endtask

    initial begin
        bit got;
        vec_t add_v, bad_v;

        vecs[0]  = '{6'h08, 6'h00, 5'd0,  5'd5,  5'd0,  16'h0007, 32'h20050007}; // addi $5,$0,7
        vecs[1]  = '{6'h23, 6'h00, 5'd1,  5'd4,  5'd0,  16'h0008, 32'h8C240008}; // lw $4,8($1)
        vecs[2]  = '{6'h04, 6'h00, 5'd1,  5'd2,  5'd0,  16'hFFFF, 32'h1022FFFF}; // beq $1,$2,-1
        vecs[3]  = '{6'h00, 6'h22, 5'd8,  5'd9,  5'd7,  16'hABCD, 32'h01093822}; // sub, imm ignored
        vecs[4]  = '{6'h0D, 6'h3F, 5'd11, 5'd10, 5'd31, 16'h1234, 32'h356A1234}; // ori, rd/funct ignored
        vecs[5]  = '{6'h2B, 6'h00, 5'd29, 5'd31, 5'd0,  16'hFFFC, 32'hAFBFFFFC}; // sw $31,-4($29)
        vecs[6]  = '{6'h05, 6'h00, 5'd3,  5'd0,  5'd0,  16'h0010, 32'h14600010}; // bne $3,$0,16
        vecs[7]  = '{6'h0A, 6'h00, 5'd4,  5'd2,  5'd0,  16'hFFFB, 32'h2882FFFB}; // slti $2,$4,-5
        vecs[8]  = '{6'h0B, 6'h00, 5'd1,  5'd1,  5'd0,  16'h0001, 32'h2C210001}; // sltiu $1,$1,1
        vecs[9]  = '{6'h0C, 6'h00, 5'd7,  5'd6,  5'd0,  16'h00FF, 32'h30E600FF}; // andi $6,$7,0xFF
        vecs[10] = '{6'h09, 6'h00, 5'd29, 5'd29, 5'd0,  16'hFFF8, 32'h27BDFFF8}; // addiu $29,$29,-8
        vecs[11] = '{6'h00, 6'h24, 5'd31, 5'd31, 5'd31, 16'h0000, 32'h03FFF824}; // and $31,$31,$31
        add_v    = '{6'h00, 6'h20, 5'd1,  5'd2,  5'd3,  16'h0000, 32'h00221820}; // add $3,$1,$2
        bad_v    = '{6'h3F, 6'h00, 5'd1,  5'd2,  5'd3,  16'h0000, 32'h0};

        // Reset state
        do_reset(3);
        @(negedge e_clk);
        chk("rst_state", 32'(state0), 32'd0);
        chk("rst_we", 32'(we0), 32'd0);
        chk("rst_ready", 32'(ready0), 32'd0);
        chk("rst_waddr", waddr0, 32'h0);
        chk("rst_count", 32'(count0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_flags", {29'd0, eop0, efull0, |drop0}, 32'd0);
        @(posedge e_clk); #1;

        // Single R-type word, one-cycle write latency after push
        wready = 1'b1;
        q0.delete();
        pulse_start();
        send(add_v, 1'b1, 1'b0, 50, got);
        chk("t1_accept", 32'(got), 32'd1);
        chk("t1_we_latency", 32'(we0), 32'd1);
        chk("t1_wdata_latency", wdata0, 32'h00221820);
        wait_done(1'b0, "t1_done");
        chk("t1_nwrites", q0.size(), 32'd1);
        if (q0.size() > 0) begin
            chk("t1_addr", q0[0][63:32], 32'h0);
            chk("t1_data", q0[0][31:0], 32'h00221820);
        end
        chk("t1_count", 32'(count0), 32'd1);
        chk("t1_state", 32'(state0), 32'd3);

        // Encoding table, streamed back-to-back in one load
        q0.delete();
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            send(vecs[i], i == 11, 1'b0, 50, got);
            chk($sformatf("tab_accept%0d", i), 32'(got), 32'd1);
        end
        wait_done(1'b0, "tab_done");
        chk("tab_nwrites", q0.size(), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < q0.size()) begin
                chk($sformatf("tab_data%0d", i), q0[i][31:0], vecs[i].exp);
                chk($sformatf("tab_addr%0d", i), q0[i][63:32], 32'(i * 4));
            end
        end
        chk("tab_count", 32'(count0), 32'd12);
        chk("tab_flags", {29'd0, eop0, efull0, |drop0}, 32'd0);

        // Back-pressure: FIFO fills after two accepts, nothing lost on release
        q0.delete();
        wready = 1'b0;
        pulse_start();
        send(vecs[0], 1'b0, 1'b0, 50, got);
        chk("bp_accept0", 32'(got), 32'd1);
        send(vecs[1], 1'b0, 1'b0, 50, got);
        chk("bp_accept1", 32'(got), 32'd1);
        @(negedge e_clk);
        chk("bp_ready_low", 32'(ready0), 32'd0);
        chk("bp_we_high", 32'(we0), 32'd1);
        chk("bp_head", wdata0, 32'h20050007);
        @(posedge e_clk); #1;
        wready = 1'b1;
        send(vecs[2], 1'b1, 1'b0, 50, got);
        chk("bp_accept2", 32'(got), 32'd1);
        wait_done(1'b0, "bp_done");
        chk("bp_nwrites", q0.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < q0.size()) begin
                chk($sformatf("bp_data%0d", i), q0[i][31:0], vecs[i].exp);
                chk($sformatf("bp_addr%0d", i), q0[i][63:32], 32'(i * 4));
            end
        end
        chk("bp_count", 32'(count0), 32'd3);

        // Unsupported opcode dropped between two good words
        q0.delete();
        pulse_start();
        send(add_v, 1'b0, 1'b0, 50, got);
        send(bad_v, 1'b0, 1'b0, 50, got);
        chk("bad_handshake", 32'(got), 32'd1);
        send(add_v, 1'b1, 1'b0, 50, got);
        wait_done(1'b0, "bad_done");
        chk("bad_err_op", 32'(eop0), 32'd1);
        chk("bad_err_full", 32'(efull0), 32'd0);
        chk("bad_drop", 32'(drop0), 32'd1);
        chk("bad_count", 32'(count0), 32'd2);
        chk("bad_nwrites", q0.size(), 32'd2);
        if (q0.size() > 1) begin
            chk("bad_addr0", q0[0][63:32], 32'h0);
            chk("bad_addr1", q0[1][63:32], 32'h4);
            chk("bad_data1", q0[1][31:0], 32'h00221820);
        end

        // Capacity limit on the 4-word instance: 6 offered, 4 written
        do_reset(2);
        q1.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send(vecs[i + 4], 1'b0, 1'b1, 50, got);
            chk($sformatf("full_accept%0d", i), 32'(got), 32'd1);
        end
        send(vecs[8], 1'b0, 1'b1, 3, got);
        chk("full_5th_refused", 32'(got), 32'd0);
        send(vecs[9], 1'b1, 1'b1, 2, got);
        chk("full_6th_refused", 32'(got), 32'd0);
        wait_done(1'b1, "full_done");
        chk("full_err_full", 32'(efull1), 32'd1);
        chk("full_err_op", 32'(eop1), 32'd0);
        chk("full_drop", 32'(drop1), 32'd1);
        chk("full_count", 32'(count1), 32'd4);
        chk("full_nwrites", q1.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < q1.size()) begin
                chk($sformatf("full_data%0d", i), q1[i][31:0], vecs[i + 4].exp);
                chk($sformatf("full_addr%0d", i), q1[i][63:32], 32'(i * 4));
            end
        end

        // Reset with two entries queued flushes the FIFO; restart reloads from 0
        do_reset(2);
        q0.delete();
        wready = 1'b0;
        pulse_start();
        send(vecs[0], 1'b0, 1'b0, 50, got);
        send(vecs[1], 1'b0, 1'b0, 50, got);
        @(negedge e_clk);
        chk("mr_we_before", 32'(we0), 32'd1);
        @(posedge e_clk); #1;
        do_reset(1);
        @(negedge e_clk);
        chk("mr_we", 32'(we0), 32'd0);
        chk("mr_state", 32'(state0), 32'd0);
        chk("mr_count", 32'(count0), 32'd0);
        chk("mr_waddr", waddr0, 32'h0);
        @(posedge e_clk); #1;
        wready = 1'b1;
        repeat (3) @(posedge e_clk);
        #1;
        chk("mr_no_writes", q0.size(), 32'd0);
        pulse_start();
        send(vecs[8], 1'b1, 1'b0, 50, got);
        wait_done(1'b0, "mr_done");
        chk("mr_nwrites", q0.size(), 32'd1);
        if (q0.size() > 0) begin
            chk("mr_addr", q0[0][63:32], 32'h0);
            chk("mr_data", q0[0][31:0], 32'h2C210001);
        end
        chk("mr_count_after", 32'(count0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
